// File: rtl/bexkat1Def.sv
// Shared bexkat definitions used by the bus arbiter and its watchdog timer.
//   arb_t   : bus owner encoding, also driven on grant_o
//   TIMER_W : width of the bus watchdog counter
package bexkat1Def;

   typedef enum bit [1:0] {
      ARB_IDLE,
      ARB_IBUS,
      ARB_DBUS
   } arb_t;

   localparam int unsigned TIMER_W = 16;

endpackage

// File: rtl/bexkat2_bus_timer.sv
// Bus watchdog. Counts cycles where the strobe is high with no ack/err and
// raises expired_o for one cycle on the TIMEOUT-th stalled cycle.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   stb_i        : shared-port strobe
//   ack_i, err_i : shared-port responses (either one restarts the count)
//   clear_i      : force the count to zero (no owner)
//   expired_o    : one-cycle timeout pulse, never set in a cycle with ack/err
module bexkat2_bus_timer
   import bexkat1Def::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic stb_i,
   input  logic ack_i,
   input  logic err_i,
   input  logic clear_i,
   output logic expired_o
);

   localparam logic [TIMER_W-1:0] Limit = TIMER_W'(TIMEOUT - 1);

   logic [TIMER_W-1:0] cnt_q, cnt_d;
   logic               stall;

   assign stall = stb_i & ~ack_i & ~err_i;

   // cnt_q holds the number of stalled cycles already completed, so the
   // TIMEOUT-th stalled cycle is the one that sees Limit.
   assign expired_o = stall & ~clear_i & (cnt_q == Limit);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear_i || !stall || expired_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/bexkat2_bus_arbiter.sv
// Two-master arbiter sharing one memory port between the instruction-fetch
// bus (ins_*) and the data bus (dat_*). A grant lasts until the owner drops
// cyc, so multi-beat sequences stay atomic. A watchdog turns a silent memory
// side into a bus error for the owner.
//   ins_*    : instruction master (read-only)
//   dat_*    : data master
//   bus_*    : shared memory port
//   grant_o  : current owner (arb_t)
// Build option: BEXKAT2_ARB_RR_EN selects round-robin on ties; otherwise the
// data master always wins a tie.
module bexkat2_bus_arbiter
   import bexkat1Def::*;
#(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            ins_cyc_i,
   input  logic            ins_stb_i,
   input  logic [AW-1:0]   ins_adr_i,
   output logic [DW-1:0]   ins_dat_o,
   output logic            ins_ack_o,
   output logic            ins_err_o,
   input  logic            dat_cyc_i,
   input  logic            dat_stb_i,
   input  logic            dat_we_i,
   input  logic [DW/8-1:0] dat_sel_i,
   input  logic [AW-1:0]   dat_adr_i,
   input  logic [DW-1:0]   dat_dat_i,
   output logic [DW-1:0]   dat_dat_o,
   output logic            dat_ack_o,
   output logic            dat_err_o,
   output logic            bus_cyc_o,
   output logic            bus_stb_o,
   output logic            bus_we_o,
   output logic [DW/8-1:0] bus_sel_o,
   output logic [AW-1:0]   bus_adr_o,
   output logic [DW-1:0]   bus_dat_o,
   input  logic [DW-1:0]   bus_dat_i,
   input  logic            bus_ack_i,
   input  logic            bus_err_i,
   output logic [1:0]      grant_o
);

   arb_t state_q, state_d;
   arb_t tie_winner;
   logic expired;
   logic ack, err;

`ifdef BEXKAT2_ARB_RR_EN
   arb_t last_q, last_d;

   // Reset value ARB_IBUS makes the first tie go to the data master.
   assign tie_winner = (last_q == ARB_DBUS) ? ARB_IBUS : ARB_DBUS;

   always_comb begin
      last_d = last_q;
      if (state_q == ARB_IDLE && state_d != ARB_IDLE) begin
         last_d = state_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_q <= ARB_IBUS;
      end else begin
         last_q <= last_d;
      end
   end
`else
   assign tie_winner = ARB_DBUS;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (ins_cyc_i && dat_cyc_i) begin
               state_d = tie_winner;
            end else if (dat_cyc_i) begin
               state_d = ARB_DBUS;
            end else if (ins_cyc_i) begin
               state_d = ARB_IBUS;
            end
         end
         // Release only; the other master waits for the IDLE cycle.
         ARB_IBUS: if (!ins_cyc_i) state_d = ARB_IDLE;
         ARB_DBUS: if (!dat_cyc_i) state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   bexkat2_bus_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .stb_i     (bus_stb_o),
      .ack_i     (bus_ack_i),
      .err_i     (bus_err_i),
      .clear_i   (state_q == ARB_IDLE),
      .expired_o (expired)
   );

   // err beats ack when both arrive; expired is already masked by ack/err.
   assign ack = bus_ack_i & ~bus_err_i;
   assign err = bus_err_i | expired;

   always_comb begin
      bus_cyc_o = 1'b0;
      bus_stb_o = 1'b0;
      bus_we_o  = 1'b0;
      bus_sel_o = '0;
      bus_adr_o = '0;
      bus_dat_o = '0;
      ins_ack_o = 1'b0;
      ins_err_o = 1'b0;
      dat_ack_o = 1'b0;
      dat_err_o = 1'b0;
      unique case (state_q)
         ARB_IBUS: begin
            bus_cyc_o = ins_cyc_i;
            bus_stb_o = ins_stb_i;
            bus_sel_o = '1;
            bus_adr_o = ins_adr_i;
            ins_ack_o = ack;
            ins_err_o = err;
         end
         ARB_DBUS: begin
            bus_cyc_o = dat_cyc_i;
            bus_stb_o = dat_stb_i;
            bus_we_o  = dat_we_i;
            bus_sel_o = dat_sel_i;
            bus_adr_o = dat_adr_i;
            bus_dat_o = dat_dat_i;
            dat_ack_o = ack;
            dat_err_o = err;
         end
         default: ;
      endcase
   end

   // Read data is broadcast, but held at zero while in reset.
   assign ins_dat_o = rst_i ? '0 : bus_dat_i;
   assign dat_dat_o = rst_i ? '0 : bus_dat_i;
   assign grant_o   = state_q;

endmodule

// File: tb/tb_bexkat2_bus_arbiter.sv
module tb_bexkat2_bus_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 8;

   logic            clk = 1'b0;
   logic            rst_i;
   logic            ins_cyc_i, ins_stb_i;
   logic [AW-1:0]   ins_adr_i;
   logic [DW-1:0]   ins_dat_o;
   logic            ins_ack_o, ins_err_o;
   logic            dat_cyc_i, dat_stb_i, dat_we_i;
   logic [DW/8-1:0] dat_sel_i;
   logic [AW-1:0]   dat_adr_i;
   logic [DW-1:0]   dat_dat_i, dat_dat_o;
   logic            dat_ack_o, dat_err_o;
   logic            bus_cyc_o, bus_stb_o, bus_we_o;
   logic [DW/8-1:0] bus_sel_o;
   logic [AW-1:0]   bus_adr_o;
   logic [DW-1:0]   bus_dat_o, bus_dat_i;
   logic            bus_ack_i, bus_err_i;
   logic [1:0]      grant_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bexkat2_bus_arbiter #(
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (TO)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .ins_cyc_i (ins_cyc_i),
      .ins_stb_i (ins_stb_i),
      .ins_adr_i (ins_adr_i),
      .ins_dat_o (ins_dat_o),
      .ins_ack_o (ins_ack_o),
      .ins_err_o (ins_err_o),
      .dat_cyc_i (dat_cyc_i),
      .dat_stb_i (dat_stb_i),
      .dat_we_i  (dat_we_i),
      .dat_sel_i (dat_sel_i),
      .dat_adr_i (dat_adr_i),
      .dat_dat_i (dat_dat_i),
      .dat_dat_o (dat_dat_o),
      .dat_ack_o (dat_ack_o),
      .dat_err_o (dat_err_o),
      .bus_cyc_o (bus_cyc_o),
      .bus_stb_o (bus_stb_o),
      .bus_we_o  (bus_we_o),
      .bus_sel_o (bus_sel_o),
      .bus_adr_o (bus_adr_o),
      .bus_dat_o (bus_dat_o),
      .bus_dat_i (bus_dat_i),
      .bus_ack_i (bus_ack_i),
      .bus_err_i (bus_err_i),
      .grant_o   (grant_o)
   );

   // Inputs change on the falling edge; registered results are read on the
   // following falling edge, combinational ones #1 after driving.
   task automatic test_reset();
      rst_i = 1'b1;
      ins_cyc_i = 0; ins_stb_i = 0; ins_adr_i = 32'h0000_0400;
      dat_cyc_i = 0; dat_stb_i = 0; dat_we_i = 0; dat_sel_i = 4'h0;
      dat_adr_i = '0; dat_dat_i = '0;
      bus_dat_i = 32'h1234_5678; bus_ack_i = 0; bus_err_i = 0;
      #1;
      checks++;
      if ({bus_cyc_o, bus_stb_o, bus_we_o, grant_o} !== 5'b0) begin
         errors++; $display("FAIL reset_ctrl got %b want 00000", {bus_cyc_o, bus_stb_o, bus_we_o, grant_o});
      end
      checks++;
      if ({ins_dat_o, dat_dat_o} !== 64'h0) begin
         errors++; $display("FAIL reset_rdata got %h want 0", {ins_dat_o, dat_dat_o});
      end
      repeat (2) @(negedge clk);
      rst_i = 1'b0;
      @(negedge clk);
      checks++;
      if (grant_o !== 2'd0) begin
         errors++; $display("FAIL reset_idle_grant got %0d want 0", grant_o);
      end
   endtask

   task automatic test_data_write();
      dat_cyc_i = 1; dat_stb_i = 1; dat_we_i = 1; dat_sel_i = 4'hF;
      dat_adr_i = 32'h0000_1000; dat_dat_i = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (bus_cyc_o !== 1'b0) begin
         errors++; $display("FAIL wr_latency bus_cyc got %b want 0", bus_cyc_o);
      end
      @(negedge clk);
      checks++;
      if ({bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, grant_o} !== {3'b111, 4'hF, 2'd2}) begin
         errors++; $display("FAIL wr_ctrl got %b want 111111110", {bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, grant_o});
      end
      checks++;
      if ({bus_adr_o, bus_dat_o} !== {32'h0000_1000, 32'hDEAD_BEEF}) begin
         errors++; $display("FAIL wr_adr_dat got %h want 00001000deadbeef", {bus_adr_o, bus_dat_o});
      end
      bus_ack_i = 1;
      #1;
      checks++;
      if ({dat_ack_o, ins_ack_o, dat_err_o, ins_err_o} !== 4'b1000) begin
         errors++; $display("FAIL wr_ack got %b want 1000", {dat_ack_o, ins_ack_o, dat_err_o, ins_err_o});
      end
      checks++;
      if ({ins_dat_o, dat_dat_o} !== {32'h1234_5678, 32'h1234_5678}) begin
         errors++; $display("FAIL rdata_bcast got %h want 1234567812345678", {ins_dat_o, dat_dat_o});
      end
      @(negedge clk);
      bus_ack_i = 0; dat_cyc_i = 0; dat_stb_i = 0; dat_we_i = 0;
      @(negedge clk);
      checks++;
      if ({grant_o, bus_cyc_o, bus_sel_o} !== 7'b0) begin
         errors++; $display("FAIL wr_release got %b want 0", {grant_o, bus_cyc_o, bus_sel_o});
      end
   endtask

   task automatic test_tie();
      logic [1:0] want3;
`ifdef BEXKAT2_ARB_RR_EN
      want3 = 2'd1;
`else
      want3 = 2'd2;
`endif
      ins_cyc_i = 1; ins_stb_i = 1; dat_cyc_i = 1; dat_stb_i = 1; dat_sel_i = 4'h3;
      @(negedge clk);
      checks++;
      if (grant_o !== 2'd2) begin
         errors++; $display("FAIL tie1 got %0d want 2", grant_o);
      end
      dat_cyc_i = 0; dat_stb_i = 0;
      @(negedge clk);
      checks++;
      if (grant_o !== 2'd0) begin
         errors++; $display("FAIL handoff_idle got %0d want 0", grant_o);
      end
      @(negedge clk);
      checks++;
      if ({grant_o, bus_we_o, bus_sel_o, bus_adr_o} !== {2'd1, 1'b0, 4'hF, 32'h0000_0400}) begin
         errors++; $display("FAIL handoff_ibus got %h want %h", {grant_o, bus_we_o, bus_sel_o, bus_adr_o}, {2'd1, 1'b0, 4'hF, 32'h0000_0400});
      end
      ins_cyc_i = 0; ins_stb_i = 0;
      @(negedge clk);
      ins_cyc_i = 1; dat_cyc_i = 1;
      @(negedge clk);
      checks++;
      if (grant_o !== 2'd2) begin
         errors++; $display("FAIL tie2 got %0d want 2", grant_o);
      end
      ins_cyc_i = 0; dat_cyc_i = 0;
      @(negedge clk);
      ins_cyc_i = 1; dat_cyc_i = 1;
      @(negedge clk);
      checks++;
      if (grant_o !== want3) begin
         errors++; $display("FAIL tie3 got %0d want %0d", grant_o, want3);
      end
      ins_cyc_i = 0; dat_cyc_i = 0;
      @(negedge clk);
   endtask

   task automatic test_atomic_beats();
      logic [AW-1:0] a;
      ins_cyc_i = 1; ins_stb_i = 1;
      dat_cyc_i = 1; dat_stb_i = 0; dat_we_i = 1; dat_sel_i = 4'hF;
      @(negedge clk);
      checks++;
      if (grant_o !== 2'd2) begin
         errors++; $display("FAIL beats_grant got %0d want 2", grant_o);
      end
      for (int b = 0; b < 3; b++) begin
         a = 32'h0000_2000 + 32'(4 * b);
         dat_stb_i = 1; dat_adr_i = a; bus_ack_i = 1;
         #1;
         checks++;
         if ({dat_ack_o, ins_ack_o, grant_o, bus_adr_o} !== {1'b1, 1'b0, 2'd2, a}) begin
            errors++; $display("FAIL beat%0d got %h want %h", b, {dat_ack_o, ins_ack_o, grant_o, bus_adr_o}, {1'b1, 1'b0, 2'd2, a});
         end
         @(negedge clk);
         dat_stb_i = 0; bus_ack_i = 0;
         @(negedge clk);
         checks++;
         if ({grant_o, ins_ack_o} !== {2'd2, 1'b0}) begin
            errors++; $display("FAIL beat%0d_gap got %b want 100", b, {grant_o, ins_ack_o});
         end
      end
      dat_cyc_i = 0; dat_we_i = 0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (grant_o !== 2'd1) begin
         errors++; $display("FAIL beats_then_ibus got %0d want 1", grant_o);
      end
      ins_cyc_i = 0; ins_stb_i = 0;
      @(negedge clk);
   endtask

   task automatic test_timeout();
      ins_cyc_i = 1; ins_stb_i = 1;
      @(negedge clk);
      for (int n = 1; n <= 8; n++) begin
         #1;
         checks++;
         if ({ins_err_o, dat_err_o, ins_ack_o} !== {(n == 8), 2'b00}) begin
            errors++; $display("FAIL timeout_cyc%0d got %b want %b", n, {ins_err_o, dat_err_o, ins_ack_o}, {(n == 8), 2'b00});
         end
         @(negedge clk);
      end
      ins_cyc_i = 0; ins_stb_i = 0;
      @(negedge clk);
      checks++;
      if ({grant_o, ins_err_o} !== 3'b000) begin
         errors++; $display("FAIL timeout_release got %b want 000", {grant_o, ins_err_o});
      end
   endtask

   task automatic test_ack_collisions();
      ins_cyc_i = 1; ins_stb_i = 1;
      @(negedge clk);
      for (int n = 1; n <= 8; n++) begin
         if (n == 8) bus_ack_i = 1;
         #1;
         checks++;
         if ({ins_ack_o, ins_err_o} !== {(n == 8), 1'b0}) begin
            errors++; $display("FAIL ack_at_expiry_cyc%0d got %b want %b", n, {ins_ack_o, ins_err_o}, {(n == 8), 1'b0});
         end
         @(negedge clk);
      end
      bus_ack_i = 1; bus_err_i = 1;
      #1;
      checks++;
      if ({ins_ack_o, ins_err_o, dat_err_o} !== 3'b010) begin
         errors++; $display("FAIL ack_err_both got %b want 010", {ins_ack_o, ins_err_o, dat_err_o});
      end
      @(negedge clk);
      bus_ack_i = 0; bus_err_i = 0; ins_cyc_i = 0; ins_stb_i = 0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_beat();
      dat_cyc_i = 1; dat_stb_i = 1; dat_we_i = 1; dat_adr_i = 32'h0000_3000;
      @(negedge clk);
      checks++;
      if (bus_cyc_o !== 1'b1) begin
         errors++; $display("FAIL prereset_cyc got %b want 1", bus_cyc_o);
      end
      #2 rst_i = 1;
      #1;
      checks++;
      if ({bus_cyc_o, bus_stb_o, bus_we_o, grant_o, bus_adr_o, dat_ack_o, dat_dat_o} !== '0) begin
         errors++; $display("FAIL async_reset got cyc=%b grant=%0d adr=%h want all 0", bus_cyc_o, grant_o, bus_adr_o);
      end
      @(negedge clk);
      rst_i = 0; ins_cyc_i = 1; ins_stb_i = 1;
      @(negedge clk);
      checks++;
      if (grant_o !== 2'd2) begin
         errors++; $display("FAIL tie_after_reset got %0d want 2", grant_o);
      end
      ins_cyc_i = 0; ins_stb_i = 0; dat_cyc_i = 0; dat_stb_i = 0; dat_we_i = 0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_data_write();
      test_tie();
      test_atomic_beats();
      test_timeout();
      test_ack_collisions();
      test_reset_mid_beat();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bexkat2_bus_arbiter.md
# bexkat2_bus_arbiter

Two-master bus arbiter for the bexkat2 CPU. It shares the single external memory port between the instruction-fetch bus, which feeds MDR_IBUS, and the data bus, which feeds MDR_DBUS. Each grant is held for the requester's whole bus cycle, so multi-beat sequences are never split: PUSH/POP, exception frame stores and RTI pops. A watchdog returns a bus error when the memory side never answers, which lets the control unit enter S_EXC instead of hanging.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width (must be a multiple of 8)
- TIMEOUT, 255, cycles with strobe high and no ack/err before error (1..65535)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- ins_cyc_i / ins_stb_i  in  1 / 1  instruction master cycle / strobe (read-only)
- ins_adr_i  in  AW  instruction address
- ins_dat_o  out  DW  read data
- ins_ack_o / ins_err_o  out  1 / 1  instruction ack / error
- dat_cyc_i / dat_stb_i / dat_we_i  in  1 / 1 / 1  data master cycle / strobe / write
- dat_sel_i  in  DW/8  byte selects
- dat_adr_i  in  AW  data address
- dat_dat_i  in  DW  write data
- dat_dat_o  out  DW  read data
- dat_ack_o / dat_err_o  out  1 / 1  data ack / error
- bus_cyc_o / bus_stb_o / bus_we_o  out  1 / 1 / 1  shared port cycle / strobe / write
- bus_sel_o  out  DW/8  byte selects
- bus_adr_o / bus_dat_o  out  AW / DW  shared address / write data
- bus_dat_i  in  DW  shared read data
- bus_ack_i / bus_err_i  in  1 / 1  shared ack / error
- grant_o  out  2  current owner, arb_t encoding

## Operation
- States:
  - ARB_IDLE: no owner.
  - ARB_IBUS: instruction master owns the port.
  - ARB_DBUS: data master owns the port.
- IDLE → owner, registered:
  - If only one cyc is high, that master is granted.
  - If both are high, the tie rule under Configuration applies.
- Owner → IDLE: on the first clock edge where the owner's cyc is low. Any other request in the same cycle is not granted until the next edge.
- Forwarding to the shared port is combinational from the owner state:
  - bus_cyc_o/bus_stb_o/bus_adr_o come from the owner's signals.
  - For the instruction owner, bus_we_o=0 and bus_sel_o=all ones.
- In IDLE, bus_cyc_o, bus_stb_o and bus_we_o are 0; bus_sel_o, bus_adr_o and bus_dat_o are 0.
- bus_dat_i is broadcast to both masters' read-data outputs.
- ack/err go only to the owner; the non-owner sees ack=0 and err=0 at all times.
- The owner's cyc is honoured regardless of the other master's requests, so sequences are atomic.
- Watchdog:
  - A 16-bit counter increments each cycle bus_stb_o=1 and bus_ack_i=0 and bus_err_i=0.
  - It clears on ack, on err, when stb is low, and in IDLE.
  - When the count reaches TIMEOUT, the owner's err_o pulses for one cycle and the counter clears.
  - The master must then drop cyc.
- Simultaneous events:
  - bus_ack_i in the timeout cycle: ack is passed through and no err is generated.
  - bus_ack_i together with bus_err_i: err is passed and ack is suppressed.

## Timing
- Reset values: state=ARB_IDLE, grant_o=0, counter=0, last-served=ARB_IBUS. All outputs are 0 in reset.
- Reset mid-transfer aborts immediately. The shared-port outputs drop asynchronously, and no ack/err is delivered.
- Grant latency:
  - cyc sampled high at edge N gives bus_cyc_o high after edge N, so there is one cycle of arbitration latency.
  - There is no latency from IDLE with a single requester beyond that cycle.
- ack/err pass through combinationally in the same cycle; there is no added data latency.
- Hand-off between masters: the owner drops cyc in cycle K, state is IDLE in K+1, and the new owner is on the bus in K+2.
- Timeout: err_o is high in the TIMEOUT-th stalled cycle after bus_stb_o rises.

## Configuration
- BEXKAT2_ARB_RR_EN defined: round-robin on ties.
  - The master that was not granted most recently wins.
  - last-served updates on every grant.
- Undefined: fixed priority on ties, with the data master always winning.
- In both modes, the first tie after reset goes to the data master.

## Structure
- Add `typedef enum bit [1:0] { ARB_IDLE, ARB_IBUS, ARB_DBUS } arb_t;` to the shared bexkat1Def package.
- TIMEOUT width (16 bits) is a package constant.
- One sub-module: bexkat2_bus_timer. It holds the watchdog counter and has inputs stb, ack, err, clear and an expired pulse output.

## Test plan
- Single data write, addr 0x1000, data 0xDEADBEEF, sel 0xF: bus_cyc_o rises one cycle after dat_cyc_i, the bus carries we=1 and the matching signals, ack returns on dat_ack_o, and ins_ack_o stays 0.
- Both cyc rise in the same cycle: grant_o=ARB_DBUS. After dat_cyc_i drops, ARB_IBUS is granted two cycles later. Repeat the tie: fixed mode gives DBUS again, RR mode gives IBUS.
- Data master holds cyc over 3 beats (stb pulsed, ack per beat) while ins_cyc_i is high throughout: no instruction beat is interleaved, and grant_o stays ARB_DBUS.
- TIMEOUT=8, instruction read with no ack: ins_err_o pulses exactly on the 8th stalled cycle and dat_err_o stays 0. Drop cyc: the state returns to IDLE.
- bus_ack_i in the same cycle the counter expires: ack is delivered and no err. Separately, ack and err together: only err is delivered.
- rst_i asserted mid-beat: bus_cyc_o goes 0 without waiting for a clock edge, grant_o=0, and after release the first tie is granted to the data master.
